// File: rtl/fib_escalonador.sv
// Round-robin scheduler sharing one iterative Fibonacci stepper among NREQ requesters.
// Response is valid n+2 cycles after grant; held stable under rsp_ready backpressure, no grants until handshake.
module fib_escalonador #(
   parameter int NREQ = 2,
   parameter int W    = 16,
   parameter int IW   = 6,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clock,
   input  logic               resete,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*IW-1:0] req_idx,
   output logic [NREQ-1:0]    grant,
   output logic               busy,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [W-1:0]       rsp_value,
   output logic               rsp_ovf
);

   typedef enum logic [1:0] {IDLE, STEP, RESP} state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id;
   logic [IDW-1:0] sel;
   logic           found;
   logic [IW-1:0]  cnt;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           ovfa;
   logic           ovfb;
   logic [W:0]     sum;

   // First set request at or after ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            sel   = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (state == IDLE && found)
         grant[sel] = 1'b1;
   end

   assign busy = (state != IDLE);
   assign sum  = {1'b0, a} + {1'b0, b};

   always_ff @(posedge clock) begin
      if (!resete) begin
         state     <= IDLE;
         ptr       <= '0;
         id        <= '0;
         cnt       <= '0;
         a         <= W'(1);
         b         <= '0;
         ovfa      <= 1'b0;
         ovfb      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_value <= '0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  id    <= sel;
                  cnt   <= req_idx[int'(sel)*IW +: IW];
                  a     <= W'(1);
                  b     <= '0;
                  ovfa  <= 1'b0;
                  ovfb  <= 1'b0;
                  state <= STEP;
               end
            end
            STEP: begin
               // b holds F(k); a is the lookahead F(k+1), whose overflow never reaches rsp_ovf directly.
               if (cnt != '0) begin
                  b    <= a;
                  a    <= sum[W-1:0];
                  ovfb <= ovfa;
                  ovfa <= ovfa | sum[W];
                  cnt  <= cnt - 1'b1;
               end else begin
                  rsp_value <= b;
                  rsp_ovf   <= ovfb;
                  rsp_id    <= id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= IDW'((int'(id) + 1) % NREQ);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_escalonador.sv
// Directed bench for fib_escalonador: table of single jobs plus round-robin and reset sequences.
module tb_fib_escalonador;

   logic        clock = 1'b0;
   logic        resete;
   logic [1:0]  req;
   logic [11:0] req_idx;
   logic [1:0]  grant;
   logic        busy;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [0:0]  rsp_id;
   logic [15:0] rsp_value;
   logic        rsp_ovf;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_bad  = 0;

   typedef struct {
      logic [1:0]  mask;
      logic [5:0]  idx0;
      logic [5:0]  idx1;
      logic [1:0]  egrant;
      int          eid;
      logic [15:0] eval;
      logic        eovf;
      int          elat;
      int          stall;
   } vec_t;

   vec_t vecs[7];

   fib_escalonador #(.NREQ(2), .W(16), .IW(6)) dut (
      .clock     (clock),
      .resete    (resete),
      .req       (req),
      .req_idx   (req_idx),
      .grant     (grant),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_value (rsp_value),
      .rsp_ovf   (rsp_ovf)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset;
      resete    = 1'b0;
      req       = '0;
      req_idx   = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      resete = 1'b1;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " grant"},     grant,     0);
      check({tag, " busy"},      busy,      0);
      check({tag, " rsp_valid"}, rsp_valid, 0);
      check({tag, " rsp_id"},    rsp_id,    0);
      check({tag, " rsp_value"}, rsp_value, 0);
      check({tag, " rsp_ovf"},   rsp_ovf,   0);
   endtask

   // One job: wait for grant, drop the served requester, wait for response, handshake.
   task automatic run_job(input vec_t v, input string tag);
      int         t;
      int         gc;
      logic [1:0] g;
      req_idx   = {v.idx1, v.idx0};
      req       = v.mask;
      rsp_ready = (v.stall == 0);
      #1;
      t = 0;
      while (grant == 2'b00 && t < 100) begin
         tick();
         t++;
      end
      check({tag, " grant"}, grant, v.egrant);
      check({tag, " busy@grant"}, busy, 0);
      g  = grant;
      gc = cyc;
      tick();
      req = v.mask & ~g;
      t = 0;
      while (!rsp_valid && t < 200) begin
         tick();
         t++;
      end
      check({tag, " latency"}, cyc - gc, v.elat);
      check({tag, " rsp_id"},    rsp_id,    v.eid);
      check({tag, " rsp_value"}, rsp_value, v.eval);
      check({tag, " rsp_ovf"},   rsp_ovf,   v.eovf);
      check({tag, " busy@rsp"},  busy,      1);
      for (int s = 0; s < v.stall; s++) begin
         req = v.mask;
         tick();
         check({tag, " hold valid"}, rsp_valid, 1);
         check({tag, " hold value"}, rsp_value, v.eval);
         check({tag, " hold id"},    rsp_id,    v.eid);
         check({tag, " hold busy"},  busy,      1);
         check({tag, " hold grant"}, grant,     0);
      end
      rsp_ready = 1'b1;
      req       = v.mask & ~g;
      tick();
      check({tag, " valid after hs"}, rsp_valid, 0);
      check({tag, " busy after hs"},  busy,      0);
   endtask

   initial begin
      int   t;
      int   gc;
      int   last_hs;
      logic seen;
      logic [1:0]  rr_grant[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [15:0] rr_val[4]   = '{16'd2, 16'd5, 16'd2, 16'd5};
      int          rr_id[4]    = '{0, 1, 0, 1};
      vec_t        v;

      vecs[0] = '{2'b01, 6'd10, 6'd0,  2'b01, 0, 16'd55,    1'b0, 12, 0};
      vecs[1] = '{2'b01, 6'd0,  6'd0,  2'b01, 0, 16'd0,     1'b0, 2,  0};
      vecs[2] = '{2'b01, 6'd1,  6'd0,  2'b01, 0, 16'd1,     1'b0, 3,  0};
      vecs[3] = '{2'b01, 6'd24, 6'd0,  2'b01, 0, 16'd46368, 1'b0, 26, 0};
      vecs[4] = '{2'b01, 6'd25, 6'd0,  2'b01, 0, 16'd9489,  1'b1, 27, 0};
      vecs[5] = '{2'b10, 6'd0,  6'd7,  2'b10, 1, 16'd13,    1'b0, 9,  5};
      vecs[6] = '{2'b10, 6'd0,  6'd63, 2'b10, 1, 16'd25826, 1'b1, 65, 0};

      do_reset();
      check_reset_outputs("reset");

      for (int i = 0; i < 7; i++)
         run_job(vecs[i], $sformatf("vec%0d", i));

      // Round robin with both requests held continuously.
      do_reset();
      req_idx   = {6'd5, 6'd3};
      req       = 2'b11;
      rsp_ready = 1'b1;
      last_hs   = 0;
      #1;
      for (int j = 0; j < 4; j++) begin
         t = 0;
         while (grant == 2'b00 && t < 100) begin
            tick();
            t++;
         end
         check($sformatf("rr%0d grant", j), grant, rr_grant[j]);
         if (j > 0)
            check($sformatf("rr%0d grant cycle", j), cyc, last_hs + 1);
         tick();
         check($sformatf("rr%0d no grant in step", j), grant, 0);
         t = 0;
         while (!rsp_valid && t < 100) begin
            tick();
            t++;
         end
         check($sformatf("rr%0d rsp_value", j), rsp_value, rr_val[j]);
         check($sformatf("rr%0d rsp_id", j),    rsp_id,    rr_id[j]);
         check($sformatf("rr%0d no grant in resp", j), grant, 0);
         last_hs = cyc;
         tick();
      end
      req = '0;
      tick();
      tick();

      // Leave ptr at 1, then reset in the middle of a long job.
      v = '{2'b01, 6'd2, 6'd0, 2'b01, 0, 16'd1, 1'b0, 4, 0};
      run_job(v, "pre");
      req_idx   = {6'd20, 6'd0};
      req       = 2'b10;
      rsp_ready = 1'b1;
      #1;
      t = 0;
      while (grant == 2'b00 && t < 100) begin
         tick();
         t++;
      end
      check("mid grant", grant, 2'b10);
      tick();
      req = '0;
      tick();
      tick();
      check("mid busy", busy, 1);
      resete = 1'b0;
      tick();
      resete = 1'b1;
      check_reset_outputs("midreset");
      seen = 1'b0;
      for (int s = 0; s < 30; s++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      check("abandoned job silent", seen, 0);

      // Both request: grant to 0 proves ptr was cleared; requester 1 follows.
      v = '{2'b11, 6'd2, 6'd6, 2'b01, 0, 16'd1, 1'b0, 4, 0};
      run_job(v, "post0");
      v = '{2'b10, 6'd2, 6'd6, 2'b10, 1, 16'd8, 1'b0, 8, 0};
      run_job(v, "post1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/fib_escalonador.md
Name: fib_escalonador

Overview:
- Scheduler that shares one iterative Fibonacci datapath between NREQ requesters.
- Each requester posts an index n. The block arbitrates round-robin, steps its internal A/B register pair n times, and returns F(n) on a valid/ready response channel with an overflow flag.
- Sits between client logic and the Fibonacci stepping datapath; owns the datapath's sequencing completely.

Parameters:
- NREQ, 2: number of requesters (1..8).
- W, 16: result width in bits.
- IW, 6: index width; n ranges 0..2^IW-1.
- IDW, derived: max(1, clog2(NREQ)), width of the requester id.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- resete  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- req_idx  in  NREQ*IW  index n of requester i in bits [i*IW +: IW].
- grant  out  NREQ  one-hot, one-cycle pulse; the request is accepted at the edge ending that cycle.
- busy  out  1  high in STEP and RESP.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  requester index of the response.
- rsp_value  out  W  F(n) mod 2^W.
- rsp_ovf  out  1  1 if the true F(n) does not fit in W bits.

Behaviour:
- Reset (resete=0 at an edge):
  - State goes to IDLE; RR pointer ptr=0.
  - grant=0, busy=0, rsp_valid=0, rsp_id=0, rsp_value=0, rsp_ovf=0.
  - Internal A=1, B=0, cnt=0, ovfA=0, ovfB=0.
  - Reset mid-operation abandons the job; no response is issued.
- FSM states: IDLE, STEP, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit searching ptr, ptr+1, … with wrap modulo NREQ.
  - grant[sel]=1 combinationally in this cycle.
  - At the edge: latch id=sel and cnt=req_idx[sel]; set A=1, B=0, ovfA=ovfB=0; go to STEP.
  - If no req bit is set: stay in IDLE, grant=0.
- STEP, cnt!=0:
  - Compute S = A+B at W+1 bits.
  - Update B<=A, A<=S[W-1:0], ovfB<=ovfA, ovfA<=ovfA|S[W], cnt<=cnt-1.
- STEP, cnt==0:
  - Load rsp_value<=B, rsp_ovf<=ovfB, rsp_id<=id; set rsp_valid<=1; go to RESP.
- Invariant: B=F(k) and A=F(k+1) mod 2^W, with ovfB/ovfA exact for each.
  - ovf therefore reflects F(n) only; overflow of the lookahead term A must not set rsp_ovf.
- RESP:
  - rsp_valid, rsp_value, rsp_id and rsp_ovf are held stable until rsp_valid&rsp_ready at an edge.
  - At that edge: rsp_valid<=0, ptr<=(id+1) mod NREQ, go to IDLE.
  - rsp_ready high before rsp_valid has no effect.
- Latency and throughput:
  - With grant in cycle c, rsp_valid is first high in cycle c+n+2 (n=0 gives c+2).
  - No new grant is issued in the cycle the response handshakes; the earliest next grant is the following cycle.
- Requester rules:
  - req_idx is sampled only in the grant cycle.
  - A requester deasserts req in the cycle after its grant if it has no further job. If req stays high, it re-enters arbitration.
  - req dropped before grant is simply not served; no state is kept.
  - grant is only ever asserted in IDLE, never more than one bit, and never while busy=1.
- Index range: cnt is IW bits wide; n=2^IW-1 is legal and returns wrapped value plus ovf.

Test Plan:
- Reset, then req[0]=1 with idx=10 (W=16), rsp_ready=1 → grant=01 in cycle c; rsp_valid in cycle c+12 with rsp_value=55, rsp_id=0, rsp_ovf=0.
- idx=0, then idx=1 → rsp_value=0 at latency 2, then rsp_value=1 at latency 3; ovf=0 for both.
- idx=24, then idx=25 (W=16) → 46368 with ovf=0 (lookahead A overflowed but must not flag), then 9489 (75025 mod 65536) with ovf=1.
- req=11 held continuously, idx0=3 and idx1=5 → grants in order 01, 10, 01, 10; responses 2 (id0), 5 (id1), …; each grant is at least one cycle after the prior handshake.
- Backpressure: idx=7 with rsp_ready=0 for 5 cycles after rsp_valid → value=13 and id held stable with busy=1 and no grant; then ready=1 → handshake, IDLE next cycle.
- resete=0 for one edge during STEP of idx=20 → all outputs return to reset values and ptr=0; a following req[1] with idx=6 returns 8 with id=1.
